// File: rtl/fetch_pc_unit.sv
// Instruction fetch PC unit: one outstanding request, delay-slot aware
// decode redirects, exception flush and a held slot towards decode.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        exception,
    input  logic [31:0] pcexception,
    input  logic        branch_taken,
    input  logic        jr,
    input  logic        jump,
    input  logic [31:0] pcbranchD,
    input  logic [31:0] pcjrD,
    input  logic [31:0] pcjumpD,
    input  logic        stallF,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        validF,
    output logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] pcplus4F
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;
    logic        discard_q, discard_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcf_q, pcf_d;

    logic        redirect;
    logic [31:0] target;
    logic        handoff;
    logic [31:0] next_pc;

    always_comb begin
        redirect = branch_taken | jr | jump;
        if (branch_taken) begin
            target = pcbranchD;
        end else if (jr) begin
            target = pcjrD;
        end else begin
            target = pcjumpD;
        end
    end

    assign handoff = (state_q == S_HOLD) && valid_q && !stallF;

    always_comb begin
        if (redirect) begin
            next_pc = target;
        end else if (pend_valid_q) begin
            next_pc = pend_target_q;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        discard_d     = discard_q;
        valid_d       = valid_q;
        instr_d       = instr_q;
        pcf_d         = pcf_q;

        if (exception) begin
            pc_d         = pcexception;
            valid_d      = 1'b0;
            pend_valid_d = 1'b0;
            state_d      = S_REQ;
            discard_d    = 1'b0;
            // A request already accepted by memory must be drained first.
            case (state_q)
                S_REQ: begin
                    if (inst_addr_ok) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!inst_data_ok) begin
                        state_d   = S_WAIT;
                        discard_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else begin
            if (redirect && !handoff) begin
                pend_valid_d  = 1'b1;
                pend_target_d = target;
            end
            case (state_q)
                S_REQ: begin
                    if (inst_addr_ok) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            state_d   = S_REQ;
                        end else begin
                            instr_d = inst_rdata;
                            pcf_d   = pc_q;
                            valid_d = 1'b1;
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (handoff) begin
                        valid_d      = 1'b0;
                        state_d      = S_REQ;
                        pc_d         = next_pc;
                        pend_valid_d = 1'b0;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_REQ;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
            discard_q     <= 1'b0;
            valid_q       <= 1'b0;
            instr_q       <= 32'd0;
            pcf_q         <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
            discard_q     <= discard_d;
            valid_q       <= valid_d;
            instr_q       <= instr_d;
            pcf_q         <= pcf_d;
        end
    end

    assign inst_req  = resetn && (state_q == S_REQ);
    assign inst_addr = pc_q;
    assign validF    = valid_q;
    assign instrF    = instr_q;
    assign pcF       = pcf_q;
    assign pcplus4F  = pcf_q + 32'd4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: transaction-level model of the fetch
// slot and outstanding request, compared every cycle, plus literal pins.
module tb_fetch_pc_unit;

    localparam logic [31:0] RPC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        exception = 1'b0;
    logic [31:0] pcexception = 32'd0;
    logic        branch_taken = 1'b0;
    logic        jr = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] pcbranchD = 32'd0;
    logic [31:0] pcjrD = 32'd0;
    logic [31:0] pcjumpD = 32'd0;
    logic        stallF = 1'b0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        validF;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pcplus4F;

    logic        aok_en = 1'b1;
    logic        dok_en = 1'b1;
    logic        mpend = 1'b0;
    logic [31:0] maddr = 32'd0;

    int checks = 0;
    int failures = 0;

    fetch_pc_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .resetn(resetn),
        .exception(exception), .pcexception(pcexception),
        .branch_taken(branch_taken), .jr(jr), .jump(jump),
        .pcbranchD(pcbranchD), .pcjrD(pcjrD), .pcjumpD(pcjumpD),
        .stallF(stallF),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .validF(validF), .instrF(instrF), .pcF(pcF), .pcplus4F(pcplus4F)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    assign inst_addr_ok = inst_req & aok_en;
    assign inst_data_ok = mpend & dok_en;
    assign inst_rdata   = memfn(maddr);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
        end
    endtask

    // Inputs sampled mid-cycle, consumed at the next rising edge.
    logic        s_acc, s_dok, s_exc, s_bt, s_jr, s_jump, s_stall;
    logic [31:0] s_addr, s_pcexc, s_pcb, s_pcjr, s_pcj;

    // Model: one outstanding request, one decode slot, one pending redirect.
    logic        m_out = 1'b0, m_drop = 1'b0;
    logic        m_slot_v = 1'b0;
    logic [31:0] m_slot_i = 32'd0, m_slot_pc = 32'd0;
    logic [31:0] m_pc = RPC;
    logic        m_pend_v = 1'b0;
    logic [31:0] m_pend_t = 32'd0;
    logic        m_ret, m_give, m_redir, exp_req;
    logic [31:0] m_tgt;

    always @(negedge clk) begin
        s_acc   = inst_req && inst_addr_ok;
        s_addr  = inst_addr;
        s_dok   = inst_data_ok;
        s_exc   = exception;
        s_pcexc = pcexception;
        s_bt    = branch_taken;
        s_jr    = jr;
        s_jump  = jump;
        s_pcb   = pcbranchD;
        s_pcjr  = pcjrD;
        s_pcj   = pcjumpD;
        s_stall = stallF;
        exp_req = resetn && !m_out && !m_slot_v;
        chk("inst_req", {31'd0, inst_req}, {31'd0, exp_req});
        if (exp_req) chk("inst_addr", inst_addr, m_pc);
        chk("validF", {31'd0, validF}, {31'd0, m_slot_v});
        if (m_slot_v) begin
            chk("instrF", instrF, m_slot_i);
            chk("pcF", pcF, m_slot_pc);
            chk("pcplus4F", pcplus4F, m_slot_pc + 32'd4);
        end
        if (!resetn) begin
            chk("rst_instrF", instrF, 32'd0);
            chk("rst_pcF", pcF, 32'd0);
        end
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_out = 0; m_drop = 0; m_slot_v = 0;
            m_slot_i = 0; m_slot_pc = 0;
            m_pc = RPC; m_pend_v = 0; m_pend_t = 0;
        end else begin
            m_ret   = m_out && s_dok;
            m_give  = m_slot_v && !s_stall;
            m_redir = s_bt || s_jr || s_jump;
            m_tgt   = s_bt ? s_pcb : (s_jr ? s_pcjr : s_pcj);
            if (s_exc) begin
                if (s_acc || (m_out && !s_dok)) begin
                    m_out = 1; m_drop = 1;
                end else begin
                    m_out = 0; m_drop = 0;
                end
                m_pc = s_pcexc; m_slot_v = 0; m_pend_v = 0;
            end else begin
                if (m_ret) begin
                    m_out = 0;
                    if (!m_drop) begin
                        m_slot_v = 1;
                        m_slot_i = memfn(m_pc);
                        m_slot_pc = m_pc;
                    end
                    m_drop = 0;
                end
                if (s_acc) m_out = 1;
                if (m_give) begin
                    m_slot_v = 0;
                    if (m_redir) m_pc = m_tgt;
                    else if (m_pend_v) m_pc = m_pend_t;
                    else m_pc = m_pc + 32'd4;
                    m_pend_v = 0;
                end else if (m_redir) begin
                    m_pend_v = 1; m_pend_t = m_tgt;
                end
            end
        end
    end

    // Memory keeps its outstanding reply across core reset.
    always @(posedge clk) begin
        if (s_dok) mpend <= 1'b0;
        if (s_acc) begin
            mpend <= 1'b1;
            maddr <= s_addr;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        while (validF !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        chk(nm, {31'd0, validF}, 32'd1);
    endtask

    task automatic req_at(input string nm, input logic [31:0] a);
        chk({nm, "_req"}, {31'd0, inst_req}, 32'd1);
        chk({nm, "_addr"}, inst_addr, a);
    endtask

    initial begin
        step(3);
        chk("reset_req", {31'd0, inst_req}, 32'd0);
        resetn = 1'b1;
        #1;
        req_at("first", RPC);

        wait_valid("seq0_wait");
        chk("seq0_pc", pcF, 32'hBFC0_0000);
        chk("seq0_instr", instrF, memfn(32'hBFC0_0000));
        chk("seq0_pc4", pcplus4F, 32'hBFC0_0004);
        step(1);

        stallF = 1'b1;
        wait_valid("stall_wait");
        for (int i = 0; i < 3; i++) begin
            chk("stall_pc", pcF, 32'hBFC0_0004);
            chk("stall_noreq", {31'd0, inst_req}, 32'd0);
            step(1);
        end
        stallF = 1'b0;
        step(1);
        req_at("after_stall", 32'hBFC0_0008);

        dok_en = 1'b0;
        step(1);
        branch_taken = 1'b1;
        pcbranchD = 32'hBFC0_0100;
        step(2);
        branch_taken = 1'b0;
        dok_en = 1'b1;
        wait_valid("dslot_wait");
        chk("dslot_pc", pcF, 32'hBFC0_0008);
        step(1);
        req_at("branch", 32'hBFC0_0100);

        wait_valid("prio_wait");
        stallF = 1'b1;
        jr = 1'b1; pcjrD = 32'hBFC0_0200;
        jump = 1'b1; pcjumpD = 32'hBFC0_0300;
        step(1);
        jr = 1'b0; jump = 1'b0; stallF = 1'b0;
        step(1);
        req_at("jr_over_jump", 32'hBFC0_0200);

        wait_valid("hjump_wait");
        jump = 1'b1; pcjumpD = 32'hBFC0_0400;
        step(1);
        jump = 1'b0;
        req_at("handoff_jump", 32'hBFC0_0400);

        wait_valid("bt_wait");
        branch_taken = 1'b1; pcbranchD = 32'hBFC0_0010;
        jr = 1'b1; pcjrD = 32'hBFC0_0500;
        step(1);
        branch_taken = 1'b0; jr = 1'b0;
        req_at("bt_over_jr", 32'hBFC0_0010);

        dok_en = 1'b0;
        jump = 1'b1; pcjumpD = 32'hBFC0_0600;
        step(1);
        jump = 1'b0;
        exception = 1'b1; pcexception = 32'hBFC0_0380;
        step(1);
        exception = 1'b0;
        chk("exc_wait_noreq", {31'd0, inst_req}, 32'd0);
        dok_en = 1'b1;
        step(1);
        chk("exc_drop_valid", {31'd0, validF}, 32'd0);
        req_at("exc_vec", 32'hBFC0_0380);
        wait_valid("exc_fetch_wait");
        chk("exc_fetch_pc", pcF, 32'hBFC0_0380);
        step(1);
        req_at("pend_cleared", 32'hBFC0_0384);

        wait_valid("exbr_wait");
        exception = 1'b1; pcexception = 32'hBFC0_0380;
        branch_taken = 1'b1; pcbranchD = 32'hBFC0_0700;
        step(1);
        exception = 1'b0; branch_taken = 1'b0;
        chk("exbr_valid", {31'd0, validF}, 32'd0);
        req_at("exbr", 32'hBFC0_0380);

        exception = 1'b1; pcexception = 32'hBFC0_0900;
        step(1);
        exception = 1'b0;
        chk("exacc_noreq", {31'd0, inst_req}, 32'd0);
        step(1);
        chk("exacc_valid", {31'd0, validF}, 32'd0);
        req_at("exacc", 32'hBFC0_0900);

        dok_en = 1'b0;
        step(1);
        resetn = 1'b0;
        #1;
        chk("rst_wait_req", {31'd0, inst_req}, 32'd0);
        chk("rst_wait_valid", {31'd0, validF}, 32'd0);
        step(1);
        resetn = 1'b1;
        aok_en = 1'b0;
        dok_en = 1'b1;
        step(1);
        chk("late_dok_valid", {31'd0, validF}, 32'd0);
        req_at("late_dok", RPC);
        aok_en = 1'b1;
        wait_valid("rst_fetch_wait");
        chk("rst_fetch_pc", pcF, RPC);

        jump = 1'b1; pcjumpD = 32'hFFFF_FFFC;
        step(1);
        jump = 1'b0;
        req_at("top", 32'hFFFF_FFFC);
        wait_valid("wrap_wait");
        chk("wrap_pc4", pcplus4F, 32'h0000_0000);
        step(1);
        req_at("wrap", 32'h0000_0000);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
